// File: rtl/axi4_frame_reader.sv
// -----------------------------------------------------------------------------
// axi4_frame_reader
//
// Purpose:
//   Memory-mapped to stream stage. On a rising edge of frame_start it reads one
//   320x240 RGB565 frame (153600 bytes) from DDR as AXI4 INCR bursts of
//   BURST_LEN x 64-bit beats, buffers the beats in an internal FWFT FIFO and
//   presents them as a 64-bit valid/ready stream tagged with start-of-frame
//   and end-of-frame. buf_select (latched at frame start) picks one of two
//   frame bases, giving double buffering against the DDR frame writer.
//
// Ports:
//   clk_100Mhz, rst              single clock, asynchronous active-high reset
//   FRAME_BASE_ADDR0/1           frame buffer base addresses
//   buf_select, frame_start      buffer select and frame request
//   AR* / R*                     AXI4 read address and read data channels
//   m_data, m_valid, m_ready     output stream (four RGB565 pixels per word)
//   m_sof, m_eof                 first / last word of the frame
//   reader_done                  one-cycle pulse when the last burst completes
//   frame_start_miss             sticky: frame_start edge arrived while busy
//   rresp_err                    sticky AXI response / RLAST error flag
//   state                        FSM state for debug
//
// Optional feature:
//   AXI_READER_ERR_CHECK_EN      when defined, rresp_err flags beats with
//                                RRESP != OKAY or a misplaced RLAST; when
//                                undefined RRESP/RLAST are ignored and
//                                rresp_err is tied low.
// -----------------------------------------------------------------------------
module axi4_frame_reader #(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int BURST_LEN        = 64,
    parameter int BURSTS_PER_FRAME = 300,
    parameter int FIFO_DEPTH       = 128
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR0,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR1,
    input  logic                      buf_select,
    input  logic                      frame_start,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sof,
    output logic                      m_eof,
    output logic                      reader_done,
    output logic                      frame_start_miss,
    output logic                      rresp_err,
    output logic [1:0]                state
);

    localparam int BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int BEAT_W      = $clog2(BURST_LEN);
    localparam int BCNT_W      = $clog2(BURSTS_PER_FRAME);
    localparam int FW          = AXI_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_RECV = 2'd2,
        NEXT      = 2'd3
    } state_t;

    state_t                    st;
    logic                      fs_d;
    logic [AXI_ADDR_WIDTH-1:0] base;
    logic [AXI_ADDR_WIDTH-1:0] offset;
    logic [BCNT_W-1:0]         burst_cnt;
    logic [BEAT_W-1:0]         beat;

    logic [FW-1:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          fifo_count;
    logic [FW-1:0]             rd_word;

    logic fs_rise;
    logic push;
    logic pop;
    logic last_beat;
    logic last_burst;
    logic fifo_space;

    assign fs_rise    = frame_start && !fs_d;
    assign push       = RVALID && RREADY;
    assign pop        = m_valid && m_ready;
    assign last_beat  = (beat == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_cnt == BCNT_W'(BURSTS_PER_FRAME - 1));
    // Only request a burst once all of it is guaranteed to fit, so RREADY can
    // stay high for the whole burst and the FIFO can never overflow.
    assign fifo_space = (fifo_count <= CNT_W'(FIFO_DEPTH - BURST_LEN));

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;
    assign state   = st;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            st               <= IDLE;
            fs_d             <= 1'b0;
            base             <= '0;
            offset           <= '0;
            burst_cnt        <= '0;
            beat             <= '0;
            ARADDR           <= '0;
            ARVALID          <= 1'b0;
            RREADY           <= 1'b0;
            reader_done      <= 1'b0;
            frame_start_miss <= 1'b0;
        end else begin
            fs_d        <= frame_start;
            reader_done <= 1'b0;
            if (fs_rise && st != IDLE)
                frame_start_miss <= 1'b1;

            case (st)
                IDLE: begin
                    if (fs_rise) begin
                        base      <= buf_select ? FRAME_BASE_ADDR1 : FRAME_BASE_ADDR0;
                        offset    <= '0;
                        burst_cnt <= '0;
                        st        <= ADDR_SEND;
                    end
                end
                ADDR_SEND: begin
                    if (ARVALID) begin
                        if (ARREADY) begin
                            ARVALID <= 1'b0;
                            RREADY  <= 1'b1;
                            beat    <= '0;
                            st      <= DATA_RECV;
                        end
                    end else if (fifo_space) begin
                        ARVALID <= 1'b1;
                        ARADDR  <= base + offset;
                    end
                end
                DATA_RECV: begin
                    // The beat count, not RLAST, decides where a burst ends.
                    if (push) begin
                        beat <= beat + BEAT_W'(1);
                        if (last_beat) begin
                            RREADY <= 1'b0;
                            st     <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    offset    <= offset + AXI_ADDR_WIDTH'(BURST_BYTES);
                    burst_cnt <= burst_cnt + BCNT_W'(1);
                    if (last_burst) begin
                        reader_done <= 1'b1;
                        st          <= IDLE;
                    end else begin
                        st <= ADDR_SEND;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; flushing is done by clearing the
    // pointers and count, and an empty FIFO never exposes stale entries.
    always_ff @(posedge clk_100Mhz) begin
        if (push)
            fifo_mem[wr_ptr] <= {RDATA,
                                 (burst_cnt == '0) && (beat == '0),
                                 last_burst && last_beat};
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // First-word fall-through: the head entry is shown directly; it is gated
    // to zero while empty so the stream outputs read 0 after reset.
    assign m_valid = (fifo_count != '0);
    assign rd_word = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_data  = rd_word[FW-1:2];
    assign m_sof   = rd_word[1];
    assign m_eof   = rd_word[0];

`ifdef AXI_READER_ERR_CHECK_EN
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst)
            rresp_err <= 1'b0;
        else if (push && ((RRESP != 2'b00) || (RLAST != last_beat)))
            rresp_err <= 1'b1;
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = ^{RRESP, RLAST};
    assign rresp_err         = 1'b0;
`endif

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
- Memory-Mapped to Stream stage downstream of the DDR frame writer.
- Reads one completed 320x240 RGB565 frame (153600 bytes) from DDR as AXI4 INCR bursts of 64 x 64-bit beats and buffers the beats in an internal FWFT FIFO.
- Presents the frame as a 64-bit valid/ready stream with start-of-frame and end-of-frame tags; the HDMI-side clock-crossing FIFO consumes it.
- Double-buffered: buf_select picks which of two frame bases is read.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI and stream data width
- BURST_LEN, 64, beats per burst (ARLEN = BURST_LEN-1)
- BURSTS_PER_FRAME, 300, bursts per frame (300 x 512 B = 153600 B)
- FIFO_DEPTH, 128, internal FIFO entries (power of 2, >= 2*BURST_LEN)

Ports:
- clk_100Mhz  in  1  single clock for AXI and stream
- rst  in  1  asynchronous, active-high reset
- FRAME_BASE_ADDR0  in  32  frame buffer 0 base
- FRAME_BASE_ADDR1  in  32  frame buffer 1 base
- buf_select  in  1  0 selects ADDR0, 1 selects ADDR1; latched at frame start
- frame_start  in  1  level or pulse; rising edge requests one frame read
- ARADDR  out  32  burst address
- ARVALID  out  1  address valid
- ARREADY  in  1  address ready
- ARLEN  out  8  constant BURST_LEN-1 (63)
- ARSIZE  out  3  constant 3'b011
- ARBURST  out  2  constant 2'b01 (INCR)
- ARCACHE  out  4  constant 4'b0011
- ARPROT  out  3  constant 3'b000
- RDATA  in  64  read data
- RVALID  in  1  read valid
- RREADY  out  1  read ready
- RLAST  in  1  last beat
- RRESP  in  2  read response
- m_data  out  64  stream data (4 RGB565 pixels)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_sof  out  1  high with first word of frame
- m_eof  out  1  high with last word of frame
- reader_done  out  1  one-cycle pulse when last burst completes
- frame_start_miss  out  1  sticky: frame_start edge arrived while busy
- rresp_err  out  1  sticky error flag (optional feature)
- state  out  2  FSM state for debug

Behaviour:
- Reset:
  - All outputs 0; state=IDLE; FIFO flushed; counters cleared.
  - Reset mid-burst abandons the transfer. The interconnect is reset together with the block.
- FSM states: IDLE=0, ADDR_SEND=1, DATA_RECV=2, NEXT=3.
- IDLE:
  - frame_start rising edge (registered delay compare) sampled at edge N: latch base = buf_select ? ADDR1 : ADDR0, clear offset and burst_cnt, state=ADDR_SEND at N+1.
- ADDR_SEND:
  - Drive ARADDR = base + offset.
  - Assert ARVALID (registered) only when fifo_count + 0 <= FIFO_DEPTH - BURST_LEN, so a whole burst always fits.
  - Hold ARVALID and ARADDR stable until ARVALID && ARREADY; then deassert ARVALID and go to DATA_RECV.
  - Best case: ARVALID high at N+2.
- DATA_RECV:
  - RREADY=1 (space guaranteed by the check above).
  - Each RVALID beat is written to the FIFO with tags sof = (burst_cnt==0 && beat==0) and eof = (burst_cnt==BURSTS_PER_FRAME-1 && beat==BURST_LEN-1).
  - After beat BURST_LEN-1 is accepted: RREADY=0, go to NEXT.
- NEXT (one cycle):
  - offset += 512; burst_cnt += 1.
  - If burst_cnt was BURSTS_PER_FRAME-1: pulse reader_done, go to IDLE. Otherwise go to ADDR_SEND.
  - Last burst address = base + 153088.
- frame_start edge outside IDLE: ignored; set frame_start_miss (sticky until rst).
- FIFO:
  - Synchronous, FWFT, 66 bits wide (data + sof + eof).
  - m_valid = !empty; pop on m_valid && m_ready.
  - A beat written at edge M is visible on m_data at M+1 when the FIFO was empty.
  - m_data, m_sof and m_eof are held stable while m_valid && !m_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow cannot occur by construction; the bench asserts this.
- Stream per frame: exactly 19200 words, m_sof on word 0, m_eof on word 19199.
- Next frame's reads may begin while the previous frame's tail is still in the FIFO; tags keep the frames separated.

Optional Feature:
- Macro AXI_READER_ERR_CHECK_EN.
- Defined: rresp_err is set (sticky until rst) when any accepted beat has RRESP!=2'b00, when RLAST=1 on a beat other than BURST_LEN-1, or when RLAST=0 on beat BURST_LEN-1. Data is still forwarded and the FSM still advances by beat count.
- Undefined: RRESP and RLAST are ignored and rresp_err is tied 0.

Test Plan:
- Reset and zero-wait slave, buf_select=0, ADDR0=0x1000_0000, m_ready=1 -> 300 AR handshakes at 0x1000_0000 + k*512, ARLEN=63; 19200 words out matching memory; m_sof on word 0, m_eof on word 19199; one reader_done pulse.
- buf_select=1, ADDR1=0x1100_0000; toggle buf_select mid-frame -> every ARADDR stays in the 0x1100_0000 region for the whole frame.
- m_ready=0 for 2000 cycles -> at most 2 bursts accepted (FIFO holds 128); ARVALID stays 0 while count>64; no data lost or reordered after m_ready returns.
- Random ARREADY/RVALID stalls plus m_ready 50% toggle -> output equals memory contents; m_data stable under backpressure.
- Second frame_start edge during burst 10 -> frame_start_miss=1; the frame still completes normally.
- With AXI_READER_ERR_CHECK_EN, RRESP=2'b10 on beat 5 of burst 3 -> rresp_err=1 and frame still completes; without the macro, rresp_err stays 0. Assert rst during DATA_RECV -> next cycle all outputs 0, m_valid=0.
